// File: rtl/flpt_pkg.sv
// Shared definitions for the FIR floating-point datapath blocks:
// default mantissa geometry, FSM state encoding and a small sizing helper.
package flpt_pkg;

    localparam int FLPT_WIDTH = 10;
    localparam int FLPT_CHUNK = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        NEG  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Width of a counter that indexes n items; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/flpt_chunk_adder.sv
// CHUNK-bit ripple-carry adder built from a chain of full_adder cells.
// The single-bit full_adder cell is kept in this file alongside its only user.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

module flpt_chunk_adder #(
    parameter int CHUNK = 5
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout
);

    logic [CHUNK:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        full_adder u_fa (
            .a    (x[i]),
            .b    (y[i]),
            .cin  (c[i]),
            .s    (s[i]),
            .cout (c[i+1])
        );
    end

    assign cout = c[CHUNK];

endmodule

// File: rtl/flpt_mantissa_addsub.sv
// Multi-cycle mantissa adder/subtractor. Adds CHUNK bits per cycle with a
// registered inter-chunk carry; subtract mode returns sign-magnitude by
// running a second chunked pass that two's-complement negates a negative
// difference.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. in_ready is 1 only in IDLE, out_valid only in DONE; both are pure
// decodes of the state. Operands are captured on the input transfer and
// later input changes are ignored; results hold stable in DONE until the
// output transfer.
module flpt_mantissa_addsub
    import flpt_pkg::*;
#(
    parameter int WIDTH = FLPT_WIDTH,
    parameter int CHUNK = FLPT_CHUNK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   z,
    output logic             neg,
    output logic             zero,
    output logic [1:0]       state_dbg
);

    localparam int N  = WIDTH / CHUNK;
    localparam int KW = idx_width(N);
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    state_t            state;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic              sub_q;
    logic [KW-1:0]     k;
    logic              carry;
    logic [WIDTH:0]    z_q;
    logic              neg_q;
    logic              zero_q;

    logic [CHUNK-1:0]  a_chunk;
    logic [CHUNK-1:0]  b_chunk;
    logic [CHUNK-1:0]  z_chunk;
    logic [CHUNK-1:0]  add_x;
    logic [CHUNK-1:0]  add_y;
    logic [CHUNK-1:0]  sum;
    logic              cout;
    logic [WIDTH:0]    z_next;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign z         = z_q;
    assign neg       = neg_q;
    assign zero      = zero_q;
    assign state_dbg = state;

    // Select chunk k of each operand and of the running result.
    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        z_chunk = '0;
        for (int i = 0; i < N; i++) begin
            if (k == KW'(i)) begin
                a_chunk = a_q[i*CHUNK +: CHUNK];
                b_chunk = b_q[i*CHUNK +: CHUNK];
                z_chunk = z_q[i*CHUNK +: CHUNK];
            end
        end
    end

    // Operand mux for the shared adder: A + (B or ~B) in ADD, ~z + carry in NEG.
    always_comb begin
        if (state == NEG) begin
            add_x = ~z_chunk;
            add_y = '0;
        end else begin
            add_x = a_chunk;
            add_y = sub_q ? ~b_chunk : b_chunk;
        end
    end

    flpt_chunk_adder #(
        .CHUNK (CHUNK)
    ) u_chunk_adder (
        .x    (add_x),
        .y    (add_y),
        .cin  (carry),
        .s    (sum),
        .cout (cout)
    );

    // Result register value after this cycle's chunk is written back; the
    // top bit carries the add-mode carry-out and stays 0 in sub mode.
    always_comb begin
        z_next = z_q;
        for (int i = 0; i < N; i++) begin
            if (k == KW'(i)) begin
                z_next[i*CHUNK +: CHUNK] = sum;
            end
        end
        if (state == ADD && k == K_LAST) begin
            z_next[WIDTH] = sub_q ? 1'b0 : cout;
        end
    end

    // Control FSM and all datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_q    <= '0;
            b_q    <= '0;
            sub_q  <= 1'b0;
            k      <= '0;
            carry  <= 1'b0;
            z_q    <= '0;
            neg_q  <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q    <= a;
                        b_q    <= b;
                        sub_q  <= sub;
                        k      <= '0;
                        carry  <= sub;
                        z_q    <= '0;
                        neg_q  <= 1'b0;
                        zero_q <= 1'b0;
                        state  <= ADD;
                    end
                end
                ADD: begin
                    z_q   <= z_next;
                    carry <= cout;
                    if (k == K_LAST) begin
                        if (!sub_q || cout) begin
                            zero_q <= (z_next == '0);
                            state  <= DONE;
                        end else begin
                            // Borrow out of the top chunk: difference is negative.
                            neg_q <= 1'b1;
                            k     <= '0;
                            carry <= 1'b1;
                            state <= NEG;
                        end
                    end else begin
                        k <= k + KW'(1);
                    end
                end
                NEG: begin
                    z_q   <= z_next;
                    carry <= cout;
                    if (k == K_LAST) begin
                        zero_q <= (z_next == '0);
                        state  <= DONE;
                    end else begin
                        k <= k + KW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/flpt_mantissa_addsub.md
# flpt_mantissa_addsub

Multi-cycle, parametrised mantissa adder/subtractor for the floating-point datapath of the FIR filter bands. It generalises the fixed 5-bit ripple-carry mantissa adder to WIDTH bits, processed CHUNK bits per cycle with a registered inter-chunk carry. It adds a subtract mode that returns a sign-magnitude result (magnitude, negative flag, zero flag) and exchanges operands over valid/ready handshakes. It sits between the exponent-align stage and the normalise stage.

## Interface
- WIDTH, 10, mantissa operand width; must be a multiple of CHUNK.
- CHUNK, 5, bits added per cycle; N = WIDTH/CHUNK.
- clk  input  1  rising-edge clock; the block's only clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand set valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  unsigned operand A.
- b  input  WIDTH  unsigned operand B.
- sub  input  1  0: A+B; 1: A−B.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- z  output  WIDTH+1  result magnitude; bit WIDTH is the carry-out in add mode and is always 0 in sub mode.
- neg  output  1  result negative; sub mode with A<B only.
- zero  output  1  z == 0.

## Operation
- States: IDLE, ADD, NEG, DONE.
- IDLE: in_ready=1. When in_valid=1, register a, b and sub, clear the chunk index k, set carry=sub, and go to ADD. Later input changes are ignored.
- ADD: each cycle, add chunk k of A to chunk k of (sub ? ~B : B) with the registered carry. Write the result to chunk k of the result register, store the carry-out, and increment k.
  - After chunk N−1, add mode: z[WIDTH]=carry, go to DONE.
  - After chunk N−1, sub mode with carry=1 (A≥B): z[WIDTH]=0, go to DONE.
  - After chunk N−1, sub mode with carry=0 (A<B): set neg=1, clear k, set carry=1, go to NEG.
- NEG: each cycle, replace chunk k with ~chunk + carry (two's-complement negation), store the carry-out, and increment k. After chunk N−1, go to DONE.
- DONE: out_valid=1. z, neg and zero are held stable. When out_ready=1, go to IDLE.
- zero is computed from the final z and is registered on entry to DONE.
- Arithmetic rules:
  - Add mode: A+B with no overflow loss; maximum 2^(WIDTH+1)−2.
  - Sub mode: |A−B| < 2^WIDTH.
  - A−A yields z=0, zero=1, neg=0.
- Outputs are registered, except in_ready and out_valid, which are decoded from state.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, z=0, neg=0, zero=0, k=0, carry=0.
- Latency from the accept edge to out_valid rising:
  - N cycles for add mode, and for sub mode with A≥B.
  - 2N cycles for sub mode with A<B.
- Throughput: one operation per N+2 cycles minimum (add mode, out_ready held 1). There is no accept in the cycle DONE exits; this bubble is intentional.
- in_ready=0 in ADD, NEG and DONE. An in_valid asserted there is not consumed.
- Backpressure: DONE may be held indefinitely; outputs stay stable.
- rst during ADD or NEG abandons the operation. out_valid never asserts for it, and in_ready=1 on the cycle after reset.
- rst coincident with an input handshake: reset wins and the operands are not captured.

## Structure
- Shared package flpt_pkg holds the state encoding (IDLE, ADD, NEG, DONE) and the default WIDTH/CHUNK constants used by the FIR floating-point blocks.
- One sub-module: flpt_chunk_adder, a CHUNK-bit ripple adder with cin/cout built from the existing full_adder cell. It is instantiated once and shared by the ADD and NEG states via an operand mux.
- The chunk index uses a counter of width clog2(N), minimum 1.

## Test plan
All scenarios use WIDTH=10, CHUNK=5.
- Add 1023+1023 -> z=2046, neg=0, zero=0; out_valid exactly 2 cycles after accept.
- Carry across the chunk boundary: add 31+1 -> z=32; add 0+0 -> z=0, zero=1.
- Sub 300−100 -> z=200, neg=0, latency 2. Sub 100−300 -> z=200, neg=1, latency 4. Sub 5−5 -> z=0, zero=1, neg=0.
- Backpressure: out_ready low for 5 cycles in DONE -> z/neg/zero stable, in_ready=0; a second in_valid is held off and then accepted in IDLE, yielding a correct second result.
- Reset mid-ADD (1 cycle after accept) and mid-NEG -> out_valid stays 0, all outputs at reset values, in_ready=1 next cycle. The next operation is correct.
- Random: 10k operations with random a, b, sub and random out_ready, checked against a reference model for z, neg and zero; latency must be N or 2N.
